// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory access arbiter: FSM states, RAM size/direction
// codes, requester IDs and the alignment rule.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DONE    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic GNT_F = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Reserved size (2'b11) is rejected the same way as a misaligned address.
    function automatic logic access_bad(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lsb[0];
            SZ_WORD: bad = (lsb != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_timer.sv
// Wait-state counter used to detect a RAM that never answers with MOC.
// Holds at zero while clr is high, counts while en is high.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic CLK,
    input  logic CLR,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(TIMEOUT));

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter between instruction fetch and data access for the 256x8 RAM,
// owning the four-phase MOV/MOC handshake, alignment checks and the wait timeout.
//
// state   | meaning
// IDLE    | choose a requester; bad requests go straight to DONE with err
// ISSUE   | mem_mov raised with the granted request's fields
// WAIT    | hold mem_* until MOC or timeout
// DONE    | one-cycle done/err pulse to the granted requester
// RELEASE | wait for MOC to drop before accepting new work
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_done,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_rw,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    output logic          mem_mov,
    output logic          mem_rw,
    output logic [1:0]    mem_size,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_moc,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_t        state;
    logic          last_grant;
    logic          grant;
    logic          pick_d;
    logic [AW-1:0] sel_addr;
    logic          sel_rw;
    logic [1:0]    sel_size;
    logic          sel_bad;
    logic [DW-1:0] wait_data;
    logic          timer_clr;
    logic          timer_en;
    logic          timer_expired;

    // D wins only when alone or when F was served last.
    always_comb begin
        pick_d   = d_req && (!f_req || (last_grant == GNT_F));
        sel_addr = pick_d ? d_addr : f_addr;
        sel_rw   = pick_d ? d_rw : RW_READ;
        sel_size = pick_d ? d_size : SZ_WORD;
        sel_bad  = access_bad(sel_size, sel_addr[1:0]);
    end

    assign wait_data = (mem_moc && (mem_rw == RW_READ)) ? mem_rdata : '0;

    // Counting from ISSUE makes the count equal the number of WAIT cycles spent.
    assign timer_clr = (state == ST_IDLE);
    assign timer_en  = (state == ST_ISSUE) || ((state == ST_WAIT) && !mem_moc);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .CLK     (CLK),
        .CLR     (CLR),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state      <= ST_IDLE;
            last_grant <= GNT_D;
            grant      <= GNT_F;
            f_done     <= 1'b0;
            f_rdata    <= '0;
            d_done     <= 1'b0;
            d_rdata    <= '0;
            err        <= 1'b0;
            mem_mov    <= 1'b0;
            mem_rw     <= 1'b0;
            mem_size   <= 2'b00;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (f_req || d_req) begin
                        grant <= pick_d;
                        if (sel_bad) begin
                            state  <= ST_DONE;
                            err    <= 1'b1;
                            f_done <= !pick_d;
                            d_done <= pick_d;
                            if (pick_d) d_rdata <= '0;
                            else        f_rdata <= '0;
                        end else begin
                            state     <= ST_ISSUE;
                            mem_mov   <= 1'b1;
                            mem_addr  <= sel_addr;
                            mem_rw    <= sel_rw;
                            mem_size  <= sel_size;
                            mem_wdata <= pick_d ? d_wdata : '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // MOC takes priority over a timeout expiring in the same cycle.
                    if (mem_moc || timer_expired) begin
                        state   <= ST_DONE;
                        mem_mov <= 1'b0;
                        err     <= !mem_moc;
                        if (grant == GNT_D) begin
                            d_done  <= 1'b1;
                            d_rdata <= wait_data;
                        end else begin
                            f_done  <= 1'b1;
                            f_rdata <= wait_data;
                        end
                    end
                end
                ST_DONE: begin
                    f_done     <= 1'b0;
                    d_done     <= 1'b0;
                    err        <= 1'b0;
                    last_grant <= grant;
                    state      <= mem_moc ? ST_RELEASE : ST_IDLE;
                end
                ST_RELEASE: begin
                    if (!mem_moc) state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed self-checking bench for mem_access_arbiter with a simple RAM responder
// that answers MOC one cycle after MOV unless told to hang.
module tb_mem_access_arbiter;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        f_req = 1'b0;
    logic [7:0]  f_addr = '0;
    logic        f_done;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_rw = 1'b1;
    logic [1:0]  d_size = 2'b10;
    logic [7:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_mov;
    logic        mem_rw;
    logic [1:0]  mem_size;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_moc;
    logic [31:0] mem_rdata;
    logic        busy;

    logic        ram_hang = 1'b0;
    logic [31:0] ram_rdata = '0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    mem_access_arbiter #(.AW(8), .DW(32), .TIMEOUT(15)) dut (
        .CLK(CLK), .CLR(CLR),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .err(err),
        .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_moc(mem_moc), .mem_rdata(mem_rdata), .busy(busy)
    );

    // RAM responder: MOC follows MOV by one cycle, giving the four-phase handshake.
    always @(posedge CLK or negedge CLR) begin
        if (!CLR) mem_moc <= 1'b0;
        else      mem_moc <= mem_mov && !ram_hang;
    end
    assign mem_rdata = ram_rdata;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 40 && busy; i++) @(negedge CLK);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle: busy=%b expected 0", name, busy); end
    endtask

    task automatic test_reset();
        CLR = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++; if (mem_mov !== 1'b0) begin n_fail++; $display("FAIL reset_mem_mov: got %b expected 0", mem_mov); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if ({f_done, d_done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {f_done, d_done, err}); end
        n_checks++; if ({f_rdata, d_rdata} !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", {f_rdata, d_rdata}); end
        n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 00", mem_addr); end
        CLR = 1'b1;
        @(negedge CLK);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    // Raise both requests together; each requester drops its request on its done pulse.
    task automatic run_pair(input string name, input int exp_first, input logic [7:0] fa, input logic [7:0] da);
        int first;
        int fp;
        int dp;
        first = -1; fp = 0; dp = 0;
        ram_rdata = 32'hC0DE0000 | {24'd0, fa};
        f_addr = fa; d_addr = da; d_rw = 1'b1; d_size = 2'b10;
        f_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 60 && (f_req || d_req); i++) begin
            @(negedge CLK);
            if (f_done) begin fp++; if (first < 0) first = 0; f_req = 1'b0; end
            if (d_done) begin dp++; if (first < 0) first = 1; d_req = 1'b0; end
        end
        repeat (3) begin
            @(negedge CLK);
            if (f_done) fp++;
            if (d_done) dp++;
        end
        f_req = 1'b0; d_req = 1'b0;
        n_checks++; if (first != exp_first) begin n_fail++; $display("FAIL %s_first: got %0d expected %0d (0=F 1=D)", name, first, exp_first); end
        n_checks++; if (fp != 1) begin n_fail++; $display("FAIL %s_f_pulses: got %0d expected 1", name, fp); end
        n_checks++; if (dp != 1) begin n_fail++; $display("FAIL %s_d_pulses: got %0d expected 1", name, dp); end
        wait_idle(name);
    endtask

    task automatic test_fetch();
        int mov_cnt;
        int done_at;
        logic err_at;
        logic [31:0] data_at;
        logic d_seen;
        mov_cnt = 0; done_at = -1; err_at = 1'bx; data_at = 'x; d_seen = 1'b0;
        ram_rdata = 32'hE3A01005;
        f_addr = 8'h04; f_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            if (mem_mov) mov_cnt++;
            if (d_done) d_seen = 1'b1;
            if (f_done && done_at < 0) begin done_at = i; err_at = err; data_at = f_rdata; f_req = 1'b0; end
        end
        f_req = 1'b0;
        n_checks++; if (mov_cnt != 2) begin n_fail++; $display("FAIL fetch_mov_cycles: got %0d expected 2", mov_cnt); end
        n_checks++; if (done_at != 3) begin n_fail++; $display("FAIL fetch_latency: got %0d expected 3", done_at); end
        n_checks++; if (data_at !== 32'hE3A01005) begin n_fail++; $display("FAIL fetch_rdata: got %h expected e3a01005", data_at); end
        n_checks++; if (err_at !== 1'b0) begin n_fail++; $display("FAIL fetch_err: got %b expected 0", err_at); end
        n_checks++; if (d_seen !== 1'b0) begin n_fail++; $display("FAIL fetch_no_d_done: got %b expected 0", d_seen); end
        wait_idle("fetch");
    endtask

    task automatic test_write();
        int mov_cnt;
        int bad_cycles;
        logic done_seen;
        logic err_at;
        mov_cnt = 0; bad_cycles = 0; done_seen = 1'b0; err_at = 1'bx;
        d_addr = 8'h2C; d_wdata = 32'hDEADBEEF; d_rw = 1'b0; d_size = 2'b10; d_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            if (mem_mov) begin
                mov_cnt++;
                if (mem_rw !== 1'b0 || mem_size !== 2'b10 || mem_addr !== 8'h2C || mem_wdata !== 32'hDEADBEEF)
                    bad_cycles++;
            end
            if (d_done && !done_seen) begin done_seen = 1'b1; err_at = err; d_req = 1'b0; end
        end
        d_req = 1'b0; d_rw = 1'b1;
        n_checks++; if (mov_cnt != 2) begin n_fail++; $display("FAIL write_mov_cycles: got %0d expected 2", mov_cnt); end
        n_checks++; if (bad_cycles != 0) begin n_fail++; $display("FAIL write_mem_fields: %0d unstable cycles, expected 0", bad_cycles); end
        n_checks++; if (done_seen !== 1'b1) begin n_fail++; $display("FAIL write_done: got %b expected 1", done_seen); end
        n_checks++; if (err_at !== 1'b0) begin n_fail++; $display("FAIL write_err: got %b expected 0", err_at); end
        wait_idle("write");
    endtask

    // Alignment vectors: {size, addr, bad}
    task automatic test_alignment();
        logic [1:0] sz [5]  = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        logic [7:0] ad [5]  = '{8'h03, 8'h02, 8'h00, 8'h03, 8'h02};
        logic       bad [5] = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
        for (int v = 0; v < 5; v++) begin
            int done_at;
            logic mov_seen;
            logic err_at;
            done_at = -1; mov_seen = 1'b0; err_at = 1'bx;
            ram_rdata = 32'h0000_00A5;
            d_size = sz[v]; d_addr = ad[v]; d_rw = 1'b1; d_req = 1'b1;
            for (int i = 1; i <= 8; i++) begin
                @(negedge CLK);
                if (mem_mov) mov_seen = 1'b1;
                if (d_done && done_at < 0) begin done_at = i; err_at = err; d_req = 1'b0; end
            end
            d_req = 1'b0;
            n_checks++; if (done_at != (bad[v] ? 1 : 3)) begin n_fail++; $display("FAIL align%0d_latency: got %0d expected %0d", v, done_at, bad[v] ? 1 : 3); end
            n_checks++; if (err_at !== bad[v]) begin n_fail++; $display("FAIL align%0d_err: got %b expected %b", v, err_at, bad[v]); end
            n_checks++; if (mov_seen !== !bad[v]) begin n_fail++; $display("FAIL align%0d_mov: got %b expected %b", v, mov_seen, !bad[v]); end
            wait_idle("align");
        end
        d_size = 2'b10;
    endtask

    task automatic test_timeout();
        int mov_cnt;
        int done_at;
        logic err_at;
        logic [31:0] data_at;
        mov_cnt = 0; done_at = -1; err_at = 1'bx; data_at = 'x;
        ram_hang = 1'b1; ram_rdata = 32'h55AA55AA;
        d_addr = 8'h08; d_rw = 1'b1; d_size = 2'b10; d_req = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (mem_mov) mov_cnt++;
            if (d_done && done_at < 0) begin done_at = i; err_at = err; data_at = d_rdata; d_req = 1'b0; end
        end
        d_req = 1'b0; ram_hang = 1'b0;
        n_checks++; if (mov_cnt != 16) begin n_fail++; $display("FAIL timeout_mov_cycles: got %0d expected 16", mov_cnt); end
        n_checks++; if (done_at != 17) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 17", done_at); end
        n_checks++; if (err_at !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b expected 1", err_at); end
        n_checks++; if (data_at !== 32'd0) begin n_fail++; $display("FAIL timeout_rdata: got %h expected 0", data_at); end
        wait_idle("timeout");
        done_at = -1; err_at = 1'bx; data_at = 'x;
        ram_rdata = 32'h12345678;
        d_addr = 8'h0C; d_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            if (d_done && done_at < 0) begin done_at = i; err_at = err; data_at = d_rdata; d_req = 1'b0; end
        end
        d_req = 1'b0;
        n_checks++; if (done_at != 3) begin n_fail++; $display("FAIL post_timeout_latency: got %0d expected 3", done_at); end
        n_checks++; if (err_at !== 1'b0) begin n_fail++; $display("FAIL post_timeout_err: got %b expected 0", err_at); end
        n_checks++; if (data_at !== 32'h12345678) begin n_fail++; $display("FAIL post_timeout_rdata: got %h expected 12345678", data_at); end
        wait_idle("post_timeout");
    endtask

    task automatic test_reset_midflight();
        int stray;
        int first;
        logic [7:0] first_addr;
        logic first_rw;
        logic got_first_mov;
        stray = 0; first = -1; first_addr = 'x; first_rw = 1'bx; got_first_mov = 1'b0;
        ram_hang = 1'b1;
        d_addr = 8'h40; d_rw = 1'b1; d_size = 2'b10; d_req = 1'b1;
        repeat (3) @(negedge CLK);
        #2 CLR = 1'b0;
        #1;
        n_checks++; if (mem_mov !== 1'b0) begin n_fail++; $display("FAIL midreset_mem_mov: got %b expected 0", mem_mov); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        ram_hang = 1'b0;
        f_addr = 8'h44; f_req = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (f_done || d_done) stray++;
        end
        CLR = 1'b1;
        for (int i = 0; i < 40 && (f_req || d_req); i++) begin
            @(negedge CLK);
            if (mem_mov && !got_first_mov) begin got_first_mov = 1'b1; first_addr = mem_addr; first_rw = mem_rw; end
            if (f_done) begin if (first < 0) first = 0; f_req = 1'b0; end
            if (d_done) begin if (first < 0) first = 1; d_req = 1'b0; end
        end
        f_req = 1'b0; d_req = 1'b0;
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses expected 0", stray); end
        n_checks++; if (first_addr !== 8'h44 || first_rw !== 1'b1) begin n_fail++; $display("FAIL midreset_first_access: addr %h rw %b expected addr 44 rw 1", first_addr, first_rw); end
        n_checks++; if (first != 0) begin n_fail++; $display("FAIL midreset_first_grant: got %0d expected 0 (F)", first); end
        wait_idle("midreset");
    endtask

    initial begin
        test_reset();
        run_pair("pair1", 0, 8'h10, 8'h20);
        test_fetch();
        run_pair("pair2", 1, 8'h14, 8'h30);
        test_write();
        test_alignment();
        test_timeout();
        test_fetch();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
